imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 70 +++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, instruction-memory write port and loader status
interface imem_loader_if #(parameter int ADDR_W = 8);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;
    modport master(
        output start, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_hold
    );
    modport slave(
        input  start, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_hold
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a header/words/XOR-checksum byte stream into instruction memory, holding the CPU until success
module imem_loader #(
    parameter int MAX_WORDS = 32,
    parameter int ADDR_W    = 8
) (
    input logic         clk,
    input logic         rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, HI, LO, WRITE, CHK, DONE, ERR} state_t;
    state_t     state, nxt;
    logic [7:0] n, hi, lo, x, idx;
    logic       xfer;
    assign xfer = bus.byte_valid & bus.byte_ready;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = bus.start ? HDR : state;
            HDR:   if (xfer) nxt = (bus.byte_in != 8'd0 && bus.byte_in <= 8'(MAX_WORDS)) ? HI : ERR;
            HI:    if (xfer) nxt = LO;
            LO:    if (xfer) nxt = WRITE;
            WRITE: nxt = (idx + 8'd1 == n) ? CHK : HI;
            CHK:   if (xfer) nxt = (bus.byte_in == x) ? DONE : ERR;
            default: nxt = IDLE;
        endcase
    end
    // The checksum byte itself is compared, never folded into x.
    always_ff @(posedge clk) begin
        if (rst) begin
            n   <= '0;
            hi  <= '0;
            lo  <= '0;
            x   <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: if (bus.start) begin
                    idx <= '0;
                    x   <= '0;
                end
                HDR: if (xfer) begin
                    n <= bus.byte_in;
                    x <= x ^ bus.byte_in;
                end
                HI: if (xfer) begin
                    hi <= bus.byte_in;
                    x  <= x ^ bus.byte_in;
                end
                LO: if (xfer) begin
                    lo <= bus.byte_in;
                    x  <= x ^ bus.byte_in;
                end
                WRITE: idx <= idx + 8'd1;
                default: ;
            endcase
        end
    end
    assign bus.byte_ready = state inside {HDR, HI, LO, CHK};
    assign bus.wr_en      = state == WRITE;
    assign bus.wr_addr    = ADDR_W'({idx, 1'b0});
    assign bus.wr_data    = {hi, lo};
    assign bus.busy       = state inside {HDR, HI, LO, WRITE, CHK};
    assign bus.done       = state == DONE;
    assign bus.error      = state == ERR;
    assign bus.cpu_hold   = state != DONE;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, hand-written corner sequences and random images against a stream-level model
module tb_imem_loader;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(8)) bus();
    imem_loader #(.MAX_WORDS(32), .ADDR_W(8)) dut(.clk(clk), .rst(rst), .bus(bus));

    int nvec = 0, nfail = 0, cyc = 0;
    bit overlap = 0;
    logic [7:0]  stim[$];
    logic [23:0] exp_w[$], got_w[$];
    bit exp_ok;
    int exp_len;

    typedef struct {
        logic [7:0] b[8];
        int len;
        int stall;
        bit pulse;
        bit done;
        int writes;
        int dur;
    } vec_t;
    vec_t tbl[6];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.wr_en) begin
        got_w.push_back({bus.wr_addr, bus.wr_data});
        if (bus.byte_ready) overlap = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {2'b0, bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                bus.busy, bus.done, bus.error, bus.cpu_hold};
    endfunction

    // Reference: parse the stream directly from the framing rules.
    task automatic build_model();
        int n;
        logic [7:0] x;
        n = int'(stim[0]);
        x = stim[0];
        exp_w.delete();
        if (n < 1 || n > 32) begin
            exp_ok = 0;
            exp_len = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({8'(2 * i), stim[1 + 2 * i], stim[2 + 2 * i]});
            x = x ^ stim[1 + 2 * i] ^ stim[2 + 2 * i];
        end
        exp_ok = stim[2 * n + 1] == x;
        exp_len = 2 * n + 2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall, input bit pulse, output bit ok);
        ok = 0;
        bus.byte_valid = 1;
        bus.byte_in = 8'($urandom);
        for (int w = 0; w < 8 && !bus.byte_ready; w++) tick();
        if (!bus.byte_ready) return;
        bus.byte_valid = 0;
        for (int s = 0; s < stall; s++) begin
            bus.start = pulse ? 1'($urandom) : 1'b0;
            tick();
        end
        bus.start = pulse ? 1'($urandom) : 1'b0;
        bus.byte_in = b;
        bus.byte_valid = 1;
        tick();
        bus.byte_valid = 0;
        bus.start = 0;
        ok = 1;
    endtask

    task automatic run_load(input string tag, input int stall, input bit pulse, output int dur);
        bit ok;
        int c0;
        build_model();
        got_w.delete();
        bus.start = 1;
        tick();
        bus.start = 0;
        c0 = cyc;
        chk({tag, "_hdr_entry"}, {bus.byte_ready, bus.wr_en, bus.busy, bus.done, bus.error, bus.cpu_hold}, 6'b101001);
        for (int i = 0; i < exp_len; i++) begin
            send_byte(stim[i], stall, pulse, ok);
            if (!ok) begin
                chk({tag, "_byte_accept"}, i, exp_len);
                break;
            end
        end
        bus.start = 0;
        bus.byte_valid = 0;
        for (int w = 0; w < 4 && bus.busy; w++) tick();
        dur = cyc - c0;
        chk({tag, "_nwrites"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), i < got_w.size() ? {8'h0, got_w[i]} : 32'hdead, {8'h0, exp_w[i]});
        chk({tag, "_done"}, bus.done, exp_ok);
        chk({tag, "_error"}, bus.error, !exp_ok);
        chk({tag, "_cpu_hold"}, bus.cpu_hold, !exp_ok);
        chk({tag, "_dur"}, dur, exp_len * (1 + stall) + exp_w.size());
    endtask

    initial begin
        int dur;
        logic [7:0] x;
        bus.start = 0;
        bus.byte_valid = 0;
        bus.byte_in = 0;

        tbl[0] = '{'{8'h02, 8'h01, 8'h2F, 8'h01, 8'h2E, 8'h03, 8'h00, 8'h00}, 6, 0, 0, 1, 2, 8};
        tbl[1] = '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 0, 0, 1};
        tbl[2] = '{'{8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 0, 0, 1};
        tbl[3] = '{'{8'h02, 8'h01, 8'h2F, 8'h01, 8'h2E, 8'h04, 8'h00, 8'h00}, 6, 0, 0, 0, 2, 8};
        tbl[4] = '{'{8'h02, 8'h01, 8'h2F, 8'h01, 8'h2E, 8'h03, 8'h00, 8'h00}, 6, 3, 1, 1, 2, 26};
        tbl[5] = '{'{8'h01, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 0, 0, 1, 1, 5};

        // Reset with random inputs, then Start with no bytes.
        for (int i = 0; i < 2; i++) begin
            bus.start = 1'($urandom);
            bus.byte_valid = 1'($urandom);
            bus.byte_in = 8'($urandom);
            tick();
        end
        chk("reset_outputs", outs(), 32'h1);
        rst = 0;
        bus.start = 1;
        bus.byte_valid = 0;
        tick();
        bus.start = 0;
        chk("start_to_hdr", outs(), {2'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 4'b1001});
        tick();
        chk("hdr_holds", outs(), {2'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 4'b1001});
        rst = 1;
        tick();
        rst = 0;

        for (int v = 0; v < 6; v++) begin
            stim.delete();
            for (int i = 0; i < tbl[v].len; i++) stim.push_back(tbl[v].b[i]);
            run_load($sformatf("vec%0d", v), tbl[v].stall, tbl[v].pulse, dur);
            chk($sformatf("vec%0d_tbl_done", v), bus.done, tbl[v].done);
            chk($sformatf("vec%0d_tbl_writes", v), got_w.size(), tbl[v].writes);
            chk($sformatf("vec%0d_tbl_dur", v), dur, tbl[v].dur);
        end

        // Full 32-word image, checksum computed here.
        stim.delete();
        stim.push_back(8'h20);
        x = 8'h20;
        for (int i = 0; i < 32; i++) begin
            stim.push_back(8'h10);
            stim.push_back(8'(i));
            x = x ^ 8'h10 ^ 8'(i);
        end
        stim.push_back(x);
        run_load("full", 0, 0, dur);
        chk("full_last_write", got_w.size() > 0 ? {8'h0, got_w[got_w.size() - 1]} : 32'hdead, {8'h0, 8'h3E, 16'h101F});
        chk("full_done", bus.done, 1);

        // Rerun and reset right after the sixth word is written.
        begin
            bit ok;
            got_w.delete();
            bus.start = 1;
            tick();
            bus.start = 0;
            for (int i = 0; i < 13; i++) send_byte(stim[i], 0, 0, ok);
            chk("midreset_in_write", bus.wr_en, 1);
            rst = 1;
            tick();
            rst = 0;
            chk("midreset_outputs", outs(), 32'h1);
            for (int i = 0; i < 6; i++) begin
                bus.byte_valid = 1;
                bus.byte_in = 8'($urandom);
                tick();
            end
            bus.byte_valid = 0;
            chk("midreset_writes", got_w.size(), 6);
            chk("midreset_idle", outs(), 32'h1);
        end

        // Random images: some bad headers, some corrupted checksums.
        for (int r = 0; r < 40; r++) begin
            int n, sel;
            stim.delete();
            sel = $urandom_range(0, 9);
            n = sel == 0 ? ($urandom_range(0, 1) == 0 ? 0 : $urandom_range(33, 255)) : $urandom_range(1, 32);
            stim.push_back(8'(n));
            x = 8'(n);
            if (sel != 0) begin
                for (int i = 0; i < 2 * n; i++) begin
                    stim.push_back(8'($urandom));
                    x = x ^ stim[stim.size() - 1];
                end
                stim.push_back(sel == 1 ? x ^ 8'($urandom_range(1, 255)) : x);
            end
            run_load($sformatf("rnd%0d", r), $urandom_range(0, 2), 1'($urandom), dur);
        end

        chk("ready_wren_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
